// File: rtl/mac_relu_unit.sv
// Signed MAC with saturating accumulator and ReLU view; 2-cycle operand-to-acc latency.
// No backpressure: a pair is accepted on every cycle en_i=1; clr_i drops everything in flight.
module mac_relu_unit #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic [ACC_W-1:0]  relu_acc_o,
    output logic              ovf_o
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = 2 * DATA_W + 2;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic        [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_q, ovf_d;

    logic signed [PROD_W-1:0] a_ext, b_ext;
    logic signed [SUM_W-1:0]  acc_ext, prod_ext, sum;
    logic                     sat_hi, sat_lo;

    // Operands widened first so the multiply is a plain full-width signed product.
    assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};

    assign acc_ext  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign prod_ext = {{(SUM_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign sum      = acc_ext + prod_ext;
    assign sat_hi   = (sum > SAT_MAX);
    assign sat_lo   = (sum < SAT_MIN);

    always_comb begin
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        if (clr_i) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (en_i) begin
                prod_d     = a_ext * b_ext;
                prod_vld_d = 1'b1;
            end
            if (prod_vld_q) begin
                if (sat_hi) begin
                    acc_d = SAT_MAX[ACC_W-1:0];
                end else if (sat_lo) begin
                    acc_d = SAT_MIN[ACC_W-1:0];
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
                ovf_d = ovf_q | sat_hi | sat_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc_o      = acc_q;
    assign ovf_o      = ovf_q;
    assign relu_acc_o = acc_q[ACC_W-1] ? '0 : acc_q;

endmodule

// File: tb/tb_mac_relu_unit.sv
// Directed bench for mac_relu_unit: hand-computed sums, saturation, clear and gap behaviour.
module tb_mac_relu_unit;

    logic        clk;
    logic        rst;
    logic        clr_i;
    logic        en_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] acc_o;
    logic [31:0] relu_acc_o;
    logic        ovf_o;

    int checks;
    int errors;

    mac_relu_unit #(.DATA_W(32), .ACC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .en_i       (en_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .acc_o      (acc_o),
        .relu_acc_o (relu_acc_o),
        .ovf_o      (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then settle 1ns past it for sampling.
    task automatic step(input logic c, input logic e, input logic [31:0] a, input logic [31:0] b);
        clr_i = c;
        en_i  = e;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b0, 1'b1, 32'd5, 32'd5);
        checks++;
        if (acc_o !== 32'd0 || relu_acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_c1: acc=%h relu=%h ovf=%b required 0/0/0", acc_o, relu_acc_o, ovf_o);
        end
        step(1'b0, 1'b1, 32'd5, 32'd5);
        checks++;
        if (acc_o !== 32'd0 || relu_acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_c2: acc=%h relu=%h ovf=%b required 0/0/0", acc_o, relu_acc_o, ovf_o);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 32'd5, 32'd5);
        step(1'b0, 1'b0, 32'd5, 32'd5);
        checks++;
        if (acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: acc=%h ovf=%b required 0/0", acc_o, ovf_o);
        end
    endtask

    task automatic test_dot3x3;
        int bv[9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        step(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'(i + 1), 32'(bv[i]));
        checks++;
        if (acc_o === 32'd18) begin
            errors++;
            $display("FAIL dot_early: acc=%0d already final one cycle too soon", $signed(acc_o));
        end
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'd18 || relu_acc_o !== 32'd18 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL dot_final: acc=%0d relu=%0d ovf=%b required 18/18/0",
                     $signed(acc_o), $signed(relu_acc_o), ovf_o);
        end
    endtask

    task automatic test_negative;
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd5, -32'sd3);
        step(1'b0, 1'b1, 32'd2, 32'd1);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'hFFFF_FFF3 || relu_acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL negative: acc=%h relu=%h ovf=%b required fffffff3/0/0", acc_o, relu_acc_o, ovf_o);
        end
    endtask

    task automatic test_saturation;
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd2);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'h7FFF_FFFF || relu_acc_o !== 32'h7FFF_FFFF || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: acc=%h relu=%h ovf=%b required 7fffffff/7fffffff/1", acc_o, relu_acc_o, ovf_o);
        end
        // Pull back inside range: no clamp now, but the flag must stay set.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'h7FFF_FFFE || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: acc=%h ovf=%b required 7ffffffe/1", acc_o, ovf_o);
        end
        step(1'b1, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr: acc=%h ovf=%b required 0/0", acc_o, ovf_o);
        end
        step(1'b0, 1'b1, 32'h8000_0000, 32'd2);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'h8000_0000 || relu_acc_o !== 32'd0 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: acc=%h relu=%h ovf=%b required 80000000/0/1", acc_o, relu_acc_o, ovf_o);
        end
    endtask

    task automatic test_clear_mid_burst;
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd3, 32'd4);
        step(1'b0, 1'b1, 32'd2, 32'd2);
        step(1'b1, 1'b1, 32'd10, 32'd10);
        checks++;
        if (acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL clrmid_zero: acc=%0d ovf=%b required 0/0", $signed(acc_o), ovf_o);
        end
        step(1'b0, 1'b1, 32'd1, 32'd7);
        checks++;
        if (acc_o !== 32'd0) begin
            errors++;
            $display("FAIL clrmid_drop: acc=%0d required 0", $signed(acc_o));
        end
        step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'd7 || relu_acc_o !== 32'd7) begin
            errors++;
            $display("FAIL clrmid_final: acc=%0d relu=%0d required 7/7", $signed(acc_o), $signed(relu_acc_o));
        end
    endtask

    task automatic test_gapped;
        step(1'b1, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 32'd2, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd9, 32'd9);
            checks++;
            if (acc_o !== 32'd6 || relu_acc_o !== 32'd6) begin
                errors++;
                $display("FAIL gap_hold%0d: acc=%0d relu=%0d required 6/6", i, $signed(acc_o), $signed(relu_acc_o));
            end
        end
        step(1'b0, 1'b1, 32'd4, 32'hFFFF_FFFF);
        checks++;
        if (acc_o !== 32'd6) begin
            errors++;
            $display("FAIL gap_latency: acc=%0d required 6", $signed(acc_o));
        end
        step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'd2 || relu_acc_o !== 32'd2) begin
            errors++;
            $display("FAIL gap_second: acc=%0d relu=%0d required 2/2", $signed(acc_o), $signed(relu_acc_o));
        end
        step(1'b0, 1'b1, 32'd1, 32'd1);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'd3 || relu_acc_o !== 32'd3 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_final: acc=%0d relu=%0d ovf=%b required 3/3/0",
                     $signed(acc_o), $signed(relu_acc_o), ovf_o);
        end
    endtask

    task automatic test_reset_mid_accum;
        step(1'b0, 1'b1, 32'd100, 32'd100);
        step(1'b0, 1'b1, 32'd50, 32'd50);
        rst = 1'b1;
        step(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0);
        checks++;
        if (acc_o !== 32'd0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: acc=%0d ovf=%b required 0/0", $signed(acc_o), ovf_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clr_i  = 1'b0;
        en_i   = 1'b0;
        a_i    = '0;
        b_i    = '0;
        #1;
        test_reset();
        test_dot3x3();
        test_negative();
        test_saturation();
        test_clear_mid_burst();
        test_gapped();
        test_reset_mid_accum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_relu_unit.md
# mac_relu_unit

Pipelined signed multiply-accumulate with saturating 32-bit accumulator and combinational ReLU output stage. The CNN engine instantiates it as the convolution datapath. The engine sends one pixel/kernel operand pair per cycle, clears the accumulator between output pixels, and writes the ReLU-rectified sum to the output feature map.

## Interface
Parameters:
- DATA_W, 32, operand width (signed two's complement)
- ACC_W, 32, accumulator and output width (signed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr  in  1  synchronous accumulator clear (start of a new dot product)
- en  in  1  operand pair valid this cycle
- a  in  DATA_W  signed operand (pixel)
- b  in  DATA_W  signed operand (kernel weight)
- acc  out  ACC_W  signed accumulated sum (registered)
- relu_acc  out  ACC_W  max(acc, 0) (combinational from acc)
- ovf  out  1  sticky saturation flag (registered)

## Operation
- Stage 1 (multiply):
  - If en, register prod = a*b at full 2*DATA_W signed precision and set prod_vld=1.
  - Otherwise prod_vld=0 and prod holds.
- Stage 2 (accumulate):
  - If prod_vld, compute sum = acc + prod in 2*DATA_W+2 bits, sign-extending both.
  - Clamp sum to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and store it in acc.
  - If clamping occurred, set ovf=1.
  - If prod_vld=0, acc holds.
- Saturation:
  - Applies on every accumulate; no wrap-around ever occurs.
  - Clamped values are 0x7FFFFFFF positive and 0x80000000 negative.
- ReLU:
  - relu_acc = 0 when acc[ACC_W-1]=1, else relu_acc = acc.
  - Purely combinational; follows acc in the same cycle.
- clr:
  - Next cycle acc=0, ovf=0, prod_vld=0.
  - The operand pair presented with clr is discarded, even if en=1.
  - Any product already in stage 1 is discarded.
- Priority: rst > clr > en.
- rst:
  - acc=0, prod=0, prod_vld=0, ovf=0, so relu_acc=0.
  - Reset mid-accumulation abandons all in-flight data.
- en gaps:
  - Idle cycles between operand pairs do not affect the result.
  - The final sum is the saturating sum of all pairs accepted since the last clr/rst.
- No handshake or back-pressure: a pair is accepted every cycle en=1.

## Timing
- Throughput: one operand pair per cycle.
- Latency:
  - A pair sampled at edge N (en=1) is in prod after edge N.
  - It is reflected in acc (and relu_acc) after edge N+1, i.e. 2 cycles.
- Final sum: for a burst ending with the last en=1 at edge N, acc is final after edge N+1. The engine samples relu_acc at N+2 or later.
- clr at edge N: acc=0 after edge N. A pair sampled at edge N-1 (in stage 1 during clr) is dropped.
- clr and en at consecutive edges: clr at N, first en at N+1 gives acc = that product after edge N+2.
- ovf asserts in the same cycle acc shows the clamped value.
- ovf stays set until clr or rst.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with en=1, a=5, b=5.
  - Required: acc=0, relu_acc=0, ovf=0 during and after rst; acc=0 until the first en after release.
- 3x3 dot product:
  - Stimulus: clr, then 9 back-to-back pairs a=1..9 with b=-1,-1,-1,0,0,0,1,1,1.
  - Required: acc=18 and relu_acc=18 two cycles after the last pair; ovf=0.
- Negative result:
  - Stimulus: clr, then a=5,b=-3 and a=2,b=1.
  - Required: acc=-13 (0xFFFFFFF3), relu_acc=0.
- Saturation:
  - Stimulus: a=0x7FFFFFFF, b=2. Then clr, then a=0x80000000, b=2.
  - Required: first case acc=0x7FFFFFFF, ovf=1, relu_acc=0x7FFFFFFF. Second case acc=0x80000000, ovf=1, relu_acc=0.
- Clear mid-burst:
  - Stimulus: pairs (3,4),(2,2); clr coincident with en pair (10,10); then pair (1,7).
  - Required: acc=0 after clr, then acc=7. The (2,2) and (10,10) products never appear.
- Gapped input:
  - Stimulus: pairs (2,3), 3 idle cycles, (4,-1), 2 idle cycles, (1,1).
  - Required: acc holds 6 across the gap, then reads 2, then 3. relu_acc tracks acc.
